ral_bus_master: RTL and testbench

//  Initiator for the 8-entry register-bank bus (add/dt/r_w, registered read data).

---
 rtl/ral_bus_master.sv | 156 +++++++++++++++
 tb/tb_ral_bus_master.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ral_bus_master.sv
// ---------------------------------------------------------------------------
// ral_bus_master
//   Bus initiator for an 8-entry register bank (add/dt/r_w bus, registered
//   read data). Takes one command at a time over a valid/ready port and
//   drives the bank bus. It keeps a mirror of every bank register and
//   returns a response carrying data and an error flag. CHECK compares the
//   live bank value against the mirror and counts mismatches.
//
// Ports
//   clk, rst_n            clock (posedge), asynchronous active-low reset
//   cmd_valid_i/ready_o   command handshake; ready only while idle
//   cmd_op_i              00 WRITE, 01 READ, 10 CHECK, 11 reserved
//   cmd_add_i, cmd_dt_i   target register and write data
//   rsp_valid_o/ready_i   response handshake
//   rsp_dt_o, rsp_err_o   response data and error flag
//   err_cnt_o             saturating CHECK mismatch counter
//   bus_add_o/dt_o/r_w_o  bank bus outputs (r_w 1 = write)
//   bus_dt_i              bank read data, valid one cycle after the address
// ---------------------------------------------------------------------------
module ral_bus_master #(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 8,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [1:0]          cmd_op_i,
    input  logic [ADDR_W-1:0]   cmd_add_i,
    input  logic [DATA_W-1:0]   cmd_dt_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_dt_o,
    output logic                rsp_err_o,
    output logic [ERRCNT_W-1:0] err_cnt_o,
    output logic [ADDR_W-1:0]   bus_add_o,
    output logic [DATA_W-1:0]   bus_dt_o,
    output logic                bus_r_w_o,
    input  logic [DATA_W-1:0]   bus_dt_i
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WR     = 3'd1;
    localparam logic [2:0] S_RD_REQ = 3'd2;
    localparam logic [2:0] S_RD_CAP = 3'd3;
    localparam logic [2:0] S_RSP    = 3'd4;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_CHECK = 2'b10;

    logic [2:0]          r_state;
    logic                r_is_check;
    logic [ADDR_W-1:0]   r_add;
    logic [DATA_W-1:0]   r_dt;
    logic [ADDR_W-1:0]   r_bus_add;
    logic [DATA_W-1:0]   r_rsp_dt;
    logic                r_rsp_err;
    logic [ERRCNT_W-1:0] r_err_cnt;
    logic [DATA_W-1:0]   r_mirror [DEPTH];

    logic                w_mismatch;

    // Counter stops at all-ones instead of wrapping back to zero.
    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v,
                                                    input logic inc);
        if (inc && (v != {ERRCNT_W{1'b1}}))
            return v + {{(ERRCNT_W-1){1'b0}}, 1'b1};
        return v;
    endfunction

    assign w_mismatch = (bus_dt_i != r_mirror[r_add]);

    assign cmd_ready_o = (r_state == S_IDLE);
    assign rsp_valid_o = (r_state == S_RSP);
    assign rsp_dt_o    = r_rsp_dt;
    assign rsp_err_o   = r_rsp_err;
    assign err_cnt_o   = r_err_cnt;

    // The address is a register so it holds its last value between cycles;
    // data and write strobe are only driven during the single WR cycle.
    assign bus_add_o = r_bus_add;
    assign bus_r_w_o = (r_state == S_WR);
    assign bus_dt_o  = (r_state == S_WR) ? r_dt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_is_check <= 1'b0;
            r_add      <= '0;
            r_dt       <= '0;
            r_bus_add  <= '0;
            r_rsp_dt   <= '0;
            r_rsp_err  <= 1'b0;
            r_err_cnt  <= '0;
            for (int i = 0; i < DEPTH; i++)
                r_mirror[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_is_check <= (cmd_op_i == OP_CHECK);
                        r_add      <= cmd_add_i;
                        r_dt       <= cmd_dt_i;
                        case (cmd_op_i)
                            OP_WRITE: begin
                                r_bus_add <= cmd_add_i;
                                r_state   <= S_WR;
                            end
                            OP_READ, OP_CHECK: begin
                                r_bus_add <= cmd_add_i;
                                r_state   <= S_RD_REQ;
                            end
                            default: begin
                                // Reserved op: answer immediately, no bus cycle.
                                r_rsp_dt  <= '0;
                                r_rsp_err <= 1'b1;
                                r_state   <= S_RSP;
                            end
                        endcase
                    end
                end
                S_WR: begin
                    r_mirror[r_add] <= r_dt;
                    r_rsp_dt        <= r_dt;
                    r_rsp_err       <= 1'b0;
                    r_state         <= S_RSP;
                end
                S_RD_REQ: begin
                    // Bank registers the address this cycle; data arrives next.
                    r_state <= S_RD_CAP;
                end
                S_RD_CAP: begin
                    r_rsp_dt <= bus_dt_i;
                    if (r_is_check) begin
                        r_rsp_err <= w_mismatch;
                        r_err_cnt <= sat_inc(r_err_cnt, w_mismatch);
                    end else begin
                        r_mirror[r_add] <= bus_dt_i;
                        r_rsp_err       <= 1'b0;
                    end
                    r_state <= S_RSP;
                end
                S_RSP: begin
                    if (rsp_ready_i)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ral_bus_master.sv
module tb_ral_bus_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [1:0] cmd_op_i;
    logic [2:0] cmd_add_i;
    logic [7:0] cmd_dt_i;
    logic       rsp_valid_o;
    logic       rsp_ready_i;
    logic [7:0] rsp_dt_o;
    logic       rsp_err_o;
    logic [7:0] err_cnt_o;
    logic [2:0] bus_add_o;
    logic [7:0] bus_dt_o;
    logic       bus_r_w_o;
    logic [7:0] bus_dt_i;

    always #5 clk = ~clk;

    ral_bus_master #(.ADDR_W(3), .DATA_W(8), .ERRCNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_add_i(cmd_add_i), .cmd_dt_i(cmd_dt_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_dt_o(rsp_dt_o), .rsp_err_o(rsp_err_o), .err_cnt_o(err_cnt_o),
        .bus_add_o(bus_add_o), .bus_dt_o(bus_dt_o), .bus_r_w_o(bus_r_w_o),
        .bus_dt_i(bus_dt_i)
    );

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bank model: registered read data, optional forced value on add 2,
    // and a back-door poke port to create mirror mismatches.
    logic [7:0] bank_mem [8];
    logic       force_en = 1'b0;
    logic       poke_en  = 1'b0;
    logic [2:0] poke_add = '0;
    logic [7:0] poke_dt  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) bank_mem[i] <= 8'h00;
            bus_dt_i <= 8'h00;
        end else begin
            if (poke_en)        bank_mem[poke_add]  <= poke_dt;
            else if (bus_r_w_o) bank_mem[bus_add_o] <= bus_dt_o;
            bus_dt_i <= (force_en && bus_add_o == 3'd2) ? 8'h11 : bank_mem[bus_add_o];
        end
    end

    // Reference model: plain arrays for bank contents and mirror.
    logic [7:0] m_bank   [8];
    logic [7:0] m_mirror [8];
    int         m_cnt;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_bank[i]   = 8'h00;
            m_mirror[i] = 8'h00;
        end
        m_cnt = 0;
    endtask

    typedef struct {
        logic [7:0] dt;
        logic       err;
        logic [7:0] cnt;
        int         first_cyc;
    } exp_t;

    exp_t sb[$];

    // Response ready: random unless a test forces it low.
    logic hold_low = 1'b0;
    initial begin
        rsp_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready_i = hold_low ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: pops an expectation on the first cycle of every response and
    // then checks the response stays unchanged until the handshake.
    logic in_rsp = 1'b0;
    exp_t cur;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_rsp = 1'b0;
        end else if (rsp_valid_o) begin
            if (!in_rsp) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid_o), 32'd0);
                end else begin
                    cur = sb.pop_front();
                    chk("rsp_dt",      32'(rsp_dt_o),  32'(cur.dt));
                    chk("rsp_err",     32'(rsp_err_o), 32'(cur.err));
                    chk("err_cnt",     32'(err_cnt_o), 32'(cur.cnt));
                    chk("rsp_latency", 32'(cyc),       32'(cur.first_cyc));
                end
                in_rsp = 1'b1;
            end else begin
                chk("rsp_dt_stable",  32'(rsp_dt_o),  32'(cur.dt));
                chk("rsp_err_stable", 32'(rsp_err_o), 32'(cur.err));
            end
            chk("ready_low_in_rsp", 32'(cmd_ready_o), 32'd0);
            if (rsp_ready_i) in_rsp = 1'b0;
        end
    end

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!cmd_ready_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        ok = cmd_ready_o;
        if (!ok) chk("cmd_ready_timeout", 32'(cmd_ready_o), 32'd1);
    endtask

    // Issue one command, predict its response, and check the bus cycle.
    task automatic issue(input logic [1:0] op, input logic [2:0] a, input logic [7:0] d);
        bit   ok;
        exp_t e;
        logic [7:0] v;
        int   lat;
        @(negedge clk);
        wait_ready(ok);
        if (!ok) return;
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_add_i   = a;
        cmd_dt_i    = d;
        v = (force_en && a == 3'd2) ? 8'h11 : m_bank[a];
        case (op)
            2'b00: begin
                m_bank[a] = d; m_mirror[a] = d;
                e.dt = d; e.err = 1'b0; lat = 2;
            end
            2'b01: begin
                m_mirror[a] = v;
                e.dt = v; e.err = 1'b0; lat = 3;
            end
            2'b10: begin
                e.dt = v; e.err = (v != m_mirror[a]);
                if (e.err && m_cnt < 255) m_cnt++;
                lat = 3;
            end
            default: begin
                e.dt = 8'h00; e.err = 1'b1; lat = 1;
            end
        endcase
        e.cnt = 8'(m_cnt);
        e.first_cyc = cyc + 1 + lat - 1;
        sb.push_back(e);
        @(posedge clk);
        #1 cmd_valid_i = 1'b0;
        @(negedge clk);
        if (op == 2'b00) begin
            chk("wr_r_w",  32'(bus_r_w_o), 32'd1);
            chk("wr_add",  32'(bus_add_o), 32'(a));
            chk("wr_dt",   32'(bus_dt_o),  32'(d));
            @(negedge clk);
            chk("wr_one_cycle", 32'(bus_r_w_o), 32'd0);
        end else if (op == 2'b11) begin
            chk("rsv_no_bus", 32'(bus_r_w_o), 32'd0);
        end else begin
            chk("rd_r_w", 32'(bus_r_w_o), 32'd0);
            chk("rd_add", 32'(bus_add_o), 32'(a));
        end
    endtask

    task automatic poke(input logic [2:0] a, input logic [7:0] d);
        bit ok;
        @(negedge clk);
        wait_ready(ok);
        if (!ok) return;
        poke_en = 1'b1; poke_add = a; poke_dt = d;
        m_bank[a] = d;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || rsp_valid_o) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || rsp_valid_o) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n = 1'b0;
        cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_add_i = '0; cmd_dt_i = '0;
        model_reset();
        #12;
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_dt",    32'(rsp_dt_o),    32'd0);
        chk("rst_rsp_err",   32'(rsp_err_o),   32'd0);
        chk("rst_err_cnt",   32'(err_cnt_o),   32'd0);
        chk("rst_bus_add",   32'(bus_add_o),   32'd0);
        chk("rst_bus_dt",    32'(bus_dt_o),    32'd0);
        chk("rst_bus_r_w",   32'(bus_r_w_o),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: write/read, write/check at top address, reserved op.
        issue(2'b00, 3'd3, 8'h5A);
        issue(2'b01, 3'd3, 8'h00);
        issue(2'b00, 3'd7, 8'hFF);
        issue(2'b10, 3'd7, 8'h00);
        issue(2'b11, 3'd4, 8'hC3);
        @(negedge clk);
        chk("rsv_no_bus_later", 32'(bus_r_w_o), 32'd0);
        drain();

        // Back-pressure: response held for 5 cycles after a READ.
        hold_low = 1'b1;
        rsp_ready_i = 1'b0;
        issue(2'b01, 3'd3, 8'h00);
        begin
            int n = 0;
            while (!rsp_valid_o && n < 20) begin @(negedge clk); n++; end
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
            chk("bp_cmd_ready", 32'(cmd_ready_o), 32'd0);
            chk("bp_no_write",  32'(bus_r_w_o),   32'd0);
            @(negedge clk);
        end
        hold_low = 1'b0;
        drain();

        // Forced mismatch on add 2, repeated until the counter saturates.
        force_en = 1'b1;
        for (int k = 0; k < 300; k++) issue(2'b10, 3'd2, 8'h00);
        drain();
        chk("err_cnt_saturated", 32'(err_cnt_o), 32'hFF);
        force_en = 1'b0;

        // Randomized mix with occasional back-door bank changes.
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 5) == 0)
                poke(3'($urandom_range(0, 7)), 8'($urandom));
            issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 8'($urandom));
        end
        drain();

        // Reset during RD_CAP aborts the read and clears the mirror.
        issue(2'b00, 3'd5, 8'hA5);
        drain();
        @(negedge clk);
        wait_ready(ok);
        cmd_valid_i = 1'b1; cmd_op_i = 2'b01; cmd_add_i = 3'd5; cmd_dt_i = 8'h00;
        @(posedge clk);
        #1 cmd_valid_i = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("mid_rst_rsp_dt",    32'(rsp_dt_o),    32'd0);
        chk("mid_rst_rsp_err",   32'(rsp_err_o),   32'd0);
        chk("mid_rst_err_cnt",   32'(err_cnt_o),   32'd0);
        chk("mid_rst_bus_add",   32'(bus_add_o),   32'd0);
        chk("mid_rst_bus_r_w",   32'(bus_r_w_o),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(2'b01, 3'd0, 8'h00);
        issue(2'b10, 3'd5, 8'h00);
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
